// File: rtl/truth_table_sequencer_if.sv
// Connection bundle between the control side and the truth-table sequencer.
// The master modport drives requests and the function-unit output; the slave is the sequencer.
interface truth_table_sequencer_if;
    logic        start;
    logic        abort;
    logic [15:0] expected;
    logic        f_in;
    logic [3:0]  vec_out;
    logic        vec_valid;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [4:0]  ones_count;
    logic [15:0] mismatch;
    logic        pass;

    modport master (
        output start, abort, expected, f_in,
        input  vec_out, vec_valid, busy, done, result, ones_count, mismatch, pass
    );

    modport slave (
        input  start, abort, expected, f_in,
        output vec_out, vec_valid, busy, done, result, ones_count, mismatch, pass
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Walks an external 4-input function unit through all 16 vectors, samples F after a
// programmable settle time, and compares the captured truth table against a golden mask.
module truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    truth_table_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  settle_cnt;
    logic [3:0]  vec;
    logic [15:0] result_q;
    logic [15:0] result_wr;
    logic [4:0]  ones_q;
    logic [15:0] mismatch_q;
    logic        pass_q;

    // NOTE: every clocked block uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults come first in every always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = SETTLE;
            SETTLE: begin
                if (bus.abort)                     state_nxt = IDLE;
                else if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (bus.abort)          state_nxt = IDLE;
                else if (vec == 4'd15)  state_nxt = DONE;
                else                    state_nxt = SETTLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Truth table as it would look once the current vector's F is written in.
    always_comb begin
        result_wr      = result_q;
        result_wr[vec] = bus.f_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            vec        <= '0;
            result_q   <= '0;
            ones_q     <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        settle_cnt <= '0;
                        vec        <= '0;
                        result_q   <= '0;
                        ones_q     <= '0;
                        mismatch_q <= '0;
                        pass_q     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        settle_cnt <= '0;
                        vec        <= '0;
                        pass_q     <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    settle_cnt <= '0;
                    if (bus.abort) begin
                        // Abort beats the sample, including the final one: nothing is captured.
                        vec    <= '0;
                        pass_q <= 1'b0;
                    end else begin
                        result_q <= result_wr;
                        ones_q   <= ones_q + {4'b0000, bus.f_in};
                        if (vec == 4'd15) begin
                            vec        <= '0;
                            mismatch_q <= result_wr ^ bus.expected;
                            pass_q     <= (result_wr == bus.expected);
                        end else begin
                            vec <= vec + 4'd1;
                        end
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    assign bus.vec_out    = vec;
    assign bus.vec_valid  = (state == SETTLE) || (state == SAMPLE);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.result     = result_q;
    assign bus.ones_count = ones_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.pass       = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: stimulus pushes expected sweep outcomes,
// a negedge monitor pops and compares them whenever done pulses.
module tb_truth_table_sequencer;

    localparam int S     = 2;
    localparam int SWEEP = 16 * (S + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_sequencer_if bus();

    truth_table_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The emulated function unit: F for vector v is tt[v].
    logic [15:0] tt = '0;
    assign bus.f_in = tt[bus.vec_out];

    typedef struct {
        logic [15:0] result;
        logic [4:0]  ones;
        logic [15:0] mismatch;
        logic        pass;
        int          done_cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] seq[$];
    int         cyc        = 0;
    int         n_cmp      = 0;
    int         n_fail     = 0;
    int         done_count = 0;
    int         bad;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference F = (AB' + A'B)(C + D') evaluated over all 16 vectors.
    function automatic logic [15:0] model_tt();
        logic [15:0] r;
        logic a, b, c, d;
        r = '0;
        for (int v = 0; v < 16; v++) begin
            {a, b, c, d} = 4'(v);
            r[v] = ((a & ~b) | (~a & b)) & (c | ~d);
        end
        return r;
    endfunction

    // Monitor: records the applied vector stream and checks each completed sweep.
    always @(negedge clk) begin
        if (!rst_n) begin
            seq.delete();
        end else if (bus.done) begin
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", {31'b0, bus.done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result",     bus.result,     mon_e.result);
                check("ones_count", bus.ones_count, mon_e.ones);
                check("mismatch",   bus.mismatch,   mon_e.mismatch);
                check("pass",       bus.pass,       mon_e.pass);
                check("done_cycle", cyc,            mon_e.done_cyc);
                check("done_busy",  bus.busy,       1);
                check("done_vec",   {bus.vec_valid, bus.vec_out}, 0);
                check("vec_seq_len", seq.size(), SWEEP);
                bad = 0;
                for (int i = 0; i < seq.size() && i < SWEEP; i++)
                    if (seq[i] != 4'(i / (S + 1))) bad++;
                check("vec_seq_bad", bad, 0);
            end
            seq.delete();
        end else if (bus.vec_valid) begin
            seq.push_back(bus.vec_out);
        end else begin
            seq.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vec_out"},   bus.vec_out,    0);
        check({tag, "_vec_valid"}, bus.vec_valid,  0);
        check({tag, "_busy"},      bus.busy,       0);
        check({tag, "_done"},      bus.done,       0);
        check({tag, "_result"},    bus.result,     0);
        check({tag, "_ones"},      bus.ones_count, 0);
        check({tag, "_mismatch"},  bus.mismatch,   0);
        check({tag, "_pass"},      bus.pass,       0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("idle_timeout", bus.busy, 0);
    endtask

    task automatic wait_vec(input logic [3:0] v);
        int n = 0;
        while (!(bus.vec_valid === 1'b1 && bus.vec_out === v) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("wait_vec_timeout", bus.vec_out, v);
    endtask

    // Launches a sweep; expected starts as x_early and settles to x a few cycles later.
    task automatic start_sweep(input logic [15:0] t, input logic [15:0] x,
                               input logic [15:0] x_early, output int accept);
        exp_t e;
        wait_idle();
        tt           = t;
        bus.expected = x_early;
        bus.start    = 1'b1;
        accept       = cyc + 1;
        e.result     = t;
        e.ones       = 5'($countones(t));
        e.mismatch   = t ^ x;
        e.pass       = (t == x);
        e.done_cyc   = accept + SWEEP;
        sb.push_back(e);
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.expected = x;
    endtask

    task automatic pulse_start_at(input int accept, input int k);
        while (cyc < accept + k - 1) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        int          a;
        int          d0;
        logic [15:0] t, x, xe;

        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.expected = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        d0 = done_count;
        repeat (20) tick();
        check("idle_no_done", done_count - d0, 0);
        check_reset_vals("idle");

        // Golden sweep
        start_sweep(model_tt(), 16'h0DD0, 16'h0DD0, a);
        wait_idle();
        check("golden_result_held", bus.result, 16'h0DD0);
        check("golden_ones_held",   bus.ones_count, 6);
        check("golden_pass_held",   bus.pass, 1);

        // Mismatch detection
        start_sweep(model_tt(), 16'h0DD1, 16'h0DD1, a);
        wait_idle();
        check("mm_mismatch_held", bus.mismatch, 16'h0001);
        check("mm_pass_held",     bus.pass, 0);

        // Saturation plus starts while busy and in DONE
        d0 = done_count;
        start_sweep(16'hFFFF, 16'hFFFF, 16'hFFFF, a);
        pulse_start_at(a, 10);
        pulse_start_at(a, 48);
        pulse_start_at(a, 49);
        repeat (5) tick();
        check("sat_single_done", done_count - d0, 1);
        check("sat_not_restarted", bus.busy, 0);
        check("sat_ones", bus.ones_count, 16);

        // Abort mid-sweep
        start_sweep(model_tt(), 16'h0DD0, 16'h0DD0, a);
        wait_vec(4'd7);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        void'(sb.pop_back());
        check("abort_busy",      bus.busy, 0);
        check("abort_vec_out",   bus.vec_out, 0);
        check("abort_vec_valid", bus.vec_valid, 0);
        check("abort_pass",      bus.pass, 0);
        d0 = done_count;
        repeat (60) tick();
        check("abort_no_done", done_count - d0, 0);
        start_sweep(model_tt(), 16'h0DD0, 16'h0DD0, a);
        wait_idle();

        // Abort coinciding with the final sample
        start_sweep(model_tt(), 16'h0DD0, 16'h0DD0, a);
        wait_vec(4'd15);
        repeat (S) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        void'(sb.pop_back());
        d0 = done_count;
        repeat (5) tick();
        check("final_abort_no_done", done_count - d0, 0);
        check("final_abort_busy",    bus.busy, 0);
        check("final_abort_pass",    bus.pass, 0);

        // Asynchronous reset mid-run
        start_sweep(model_tt(), 16'h0DD0, 16'h0DD0, a);
        wait_vec(4'd9);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        void'(sb.pop_back());
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_sweep(model_tt(), 16'h0DD0, 16'h0DD0, a);
        wait_idle();
        check("post_rst_pass", bus.pass, 1);

        // Random truth tables, expected masks and mid-sweep expected changes
        for (int i = 0; i < 6; i++) begin
            t  = 16'($urandom);
            x  = ($urandom_range(0, 1) == 0) ? t : (t ^ 16'($urandom));
            xe = 16'($urandom);
            start_sweep(t, x, xe, a);
            wait_idle();
        end

        repeat (5) tick();
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Sequences an external 4-input combinational function unit, F = f(A,B,C,D), through all 16 input vectors.
- Waits a programmable settle time per vector, then samples F and builds a 16-bit truth-table word.
- Compares the truth table against a golden mask and reports pass/fail with a start/busy/done handshake.
- Sits between the test/control logic and the function unit and drives the unit's inputs directly.

Parameters:
- SETTLE_CYCLES, 2, cycles vec_out is held stable before F is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a full 16-vector sweep; sampled only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- expected  input  16  golden truth table; bit i is the expected F for vector i.
- f_in  input  1  F output of the function unit.
- vec_out  output  4  vector driven to the unit: [3]=A, [2]=B, [1]=C, [0]=D.
- vec_valid  output  1  high while vec_out is being applied (SETTLE and SAMPLE).
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  one-cycle pulse when a sweep completes.
- result  output  16  captured truth table; bit i = F sampled for vector i.
- ones_count  output  5  number of vectors with F=1 (0..16).
- mismatch  output  16  result XOR expected, valid with done.
- pass  output  1  1 when mismatch==0, valid with done, held until next start.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE.
  - vec_out=0, vec_valid=0, busy=0, done=0.
  - result=0, ones_count=0, mismatch=0, pass=0.
  - Internal settle counter=0.
  - Reset asserted mid-sweep discards all progress immediately.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1 at a clock edge: clear result, ones_count, mismatch and pass; set vec_out=0, settle counter=0, busy=1, vec_valid=1; go to SETTLE.
  - abort is ignored in IDLE.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, go to SAMPLE.
  - vec_out is held constant.
- SAMPLE (one cycle):
  - result[vec_out] <= f_in; ones_count <= ones_count + f_in.
  - If vec_out==15: go to DONE, compute mismatch=(result with this bit written) XOR expected, pass=(mismatch==0), and assert done for that one cycle.
  - Otherwise: vec_out <= vec_out+1, counter=0, go to SETTLE.
- DONE (one cycle):
  - done=1, busy=1, vec_valid=0, vec_out returns to 0.
  - Next edge: go to IDLE, busy=0.
  - result, ones_count, mismatch and pass are held until the next accepted start.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high during cycle 16*(SETTLE_CYCLES+1)+1 counted from the edge that accepted start; with the default that is edge 49.
- Handshake:
  - start while busy is ignored; no queuing.
  - start asserted in the DONE cycle is also ignored.
- Abort:
  - abort=1 in SETTLE or SAMPLE goes to IDLE on the next edge.
  - busy=0, vec_valid=0, vec_out=0, no done pulse, pass=0.
  - Partial result is left visible but is not valid.
  - If abort and the final sample coincide, abort wins.
- Width rules:
  - ones_count is 5 bits and reaches 16 without wrapping.
  - vec_out never wraps within a sweep; the 15→0 transition happens only via DONE.
- expected is sampled only in the SAMPLE cycle of vector 15; changes mid-sweep before that cycle are allowed.

Test Plan:
1. Reset and idle: hold rst_n=0 for 3 cycles, release -> all outputs 0, busy=0, no done for 20 idle cycles.
2. Golden sweep: bench models F=(AB'+A'B)(C+D'), expected=16'h0DD0, pulse start -> vec_out steps 0..15 with each value held 3 cycles; done pulses once at edge 49 -> result=16'h0DD0, ones_count=6, mismatch=0, pass=1.
3. Mismatch detection: same model, expected=16'h0DD1 -> pass=0, mismatch=16'h0001, ones_count=6.
4. Saturation and ignored start: f_in tied 1, expected=16'hFFFF, pulse start again at cycles 10 and 48 -> exactly one done, ones_count=16, pass=1, sweep timing unchanged.
5. Abort: assert abort while vec_out=7 -> next cycle busy=0, vec_out=0, no done. A new start then gives a full correct sweep with result=16'h0DD0.
6. Reset mid-run: drop rst_n while vec_out=9 -> outputs go to reset values without waiting for clk. After release, start -> complete sweep, pass=1.
